// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// One full_adder is reused for WIDTH cycles. Operands go in LSB first and the
// sum is assembled in a right-shifting register. A start/busy/done handshake
// runs one addition at a time.
// Optional build macro SERIAL_ADD_OVF_EN adds a registered two's-complement
// overflow output, ovf.

// Single-bit combinational full adder, the shared datapath core.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             c_out
);
    // A 1-bit counter is still needed when WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] psum_nxt;

    full_adder u_fa (
        .a    (sha[0]),
        .b    (shb[0]),
        .c_in (carry),
        .sum  (fa_s),
        .c_out(fa_co)
    );

    // Each new sum bit enters at the MSB. After WIDTH shifts, bit 0 holds the
    // LSB. The shift form also works when WIDTH=1.
    assign psum_nxt = (psum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    // Sequencer FSM. busy and done are registered copies of the state, so
    // each one follows the state by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
            sha   <= '0;
            shb   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            busy <= (state != IDLE);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sha   <= a;
                        shb   <= b;
                        carry <= c_in;
                        psum  <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    psum  <= psum_nxt;
                    sha   <= sha >> 1;
                    shb   <= shb >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= psum_nxt;
                        c_out <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // On the last bit, carry is the carry into the MSB.
                        ovf   <= carry ^ fa_co;
`endif
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with WIDTH=8.
// A scoreboard queue holds the expected results.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .c_in (c_in),
        .busy (busy),
        .done (done),
        .sum  (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf  (ovf),
`endif
        .c_out(c_out)
    );

    always #5 clk = ~clk;

    // The scoreboard pops one entry for each done pulse. It samples on the
    // falling edge. A done that lasts two cycles counts as an error.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width: done high two cycles in a row, required one");
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done with empty scoreboard, sum=%h", sum);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (sum !== e.s || c_out !== e.c) begin
                    errors++;
                    $display("FAIL result: got sum=%h c_out=%b, required sum=%h c_out=%b",
                             sum, c_out, e.s, e.c);
                end
`ifdef SERIAL_ADD_OVF_EN
                checks++;
                if (ovf !== e.v) begin
                    errors++;
                    $display("FAIL ovf: got %b, required %b (sum=%h)", ovf, e.v, e.s);
                end
`endif
            end
        end
        prev_done = done;
    end

    // Reference model: compute the expected result and push it.
    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] r;
        exp_t e;
        r   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s = r[W-1:0];
        e.c = r[W];
        e.v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        sb_q.push_back(e);
    endtask

    // Drive one start pulse. The edge that accepts it is edge 0, and the
    // task returns #1 after that edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a = x; b = y; c_in = ci; start = 1'b1;
        push_exp(x, y, ci);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done and return the edge index at which it was seen. The
    // wait is bounded; a timeout counts as an error.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin n = i; break; end
        end
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within 40 cycles, required one");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
        checks++;
        if (sum !== '0) begin errors++; $display("FAIL rst_sum: got %h, required 00", sum); end
        checks++;
        if (c_out !== 1'b0) begin errors++; $display("FAIL rst_cout: got %b, required 0", c_out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_carry_wrap();
        int n;
        launch(8'hFF, 8'h01, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy: got %b, required 1", busy); end
        wait_done(n);
        // done is sampled after edge n+1 counted from edge 0.
        checks++;
        if (n + 1 != W + 1) begin
            errors++;
            $display("FAIL wrap_latency: done after edge %0d, required %0d", n + 1, W + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_carry_in();
        int n;
        launch(8'h5A, 8'h3C, 1'b1);
        a = 8'h00; b = 8'h00; c_in = 1'b0;
        wait_done(n);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int d0, d1, cnt;
        d0 = -1; d1 = -1; cnt = 0;
        a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        push_exp(8'h10, 8'h20, 1'b0);
        push_exp(8'h10, 8'h20, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (cnt == 0) d0 = i; else d1 = i;
                cnt++;
            end
        end
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (cnt != 2) begin errors++; $display("FAIL b2b_count: got %0d done pulses, required 2", cnt); end
        checks++;
        if (d1 - d0 != W + 2) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles, required %0d", d1 - d0, W + 2);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        a = 8'h33; b = 8'h44; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
        checks++;
        if (sum !== '0) begin errors++; $display("FAIL mid_sum: got %h, required 00", sum); end
        checks++;
        if (c_out !== 1'b0) begin errors++; $display("FAIL mid_cout: got %b, required 0", c_out); end
        // Any done in this window reaches the empty scoreboard and fails.
        repeat (15) @(posedge clk);
        #1;
        launch(8'h01, 8'h01, 1'b0);
        wait_done(n);
        @(posedge clk); #1;
    endtask

    task automatic test_hold_during_run();
        int n;
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(n);
        @(posedge clk); #1;
        launch(8'h7F, 8'h01, 1'b0);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i < W) begin
                checks++;
                if (sum !== 8'h00) begin
                    errors++;
                    $display("FAIL hold_sum: cycle %0d got %h, required 00", i, sum);
                end
            end
            @(posedge clk); #1;
            if (done) begin n = i; break; end
        end
        checks++;
        if (n < 0) begin errors++; $display("FAIL hold_timeout: no done, required one"); end
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        int n;
        launch(8'h7F, 8'h01, 1'b0); wait_done(n); @(posedge clk); #1;
        launch(8'hFF, 8'h01, 1'b0); wait_done(n); @(posedge clk); #1;
        launch(8'h80, 8'h80, 1'b0); wait_done(n); @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_carry_wrap();
        test_carry_in();
        test_back_to_back();
        test_reset_mid();
        test_hold_during_run();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d results never produced, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial addition sequencer. It time-shares one `full_adder` instance, its datapath core, across WIDTH clock cycles, so two WIDTH-bit operands plus carry-in are added one bit per cycle, LSB first. A start/busy/done handshake lets a host launch one addition at a time. This is the sequential counterpart to the combinational `full_adder` and reuses it unmodified.

Parameters:
- WIDTH, 8: operand and sum width in bits. Legal range is 1..32.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`, input, 1: request a new addition; sampled only in IDLE.
- `a`, input, WIDTH: operand A; latched when `start` is accepted.
- `b`, input, WIDTH: operand B; latched when `start` is accepted.
- `c_in`, input, 1: carry-in; latched when `start` is accepted.
- `busy`, output, 1: high while in RUN or DONE.
- `done`, output, 1: one-cycle pulse; `sum` and `c_out` are valid from this cycle onward.
- `sum`, output, WIDTH: registered result.
- `c_out`, output, 1: registered final carry.

Behaviour:
- Reset (`rst_n`=0 at a rising edge) sets:
  - state to IDLE;
  - `busy`, `done`, `sum`, `c_out` to 0;
  - operand shift registers, carry register and bit counter to 0.
- Reset has priority over every other event. Reset asserted mid-RUN aborts the operation with no `done` pulse.
- State IDLE:
  - `start`=1 at an edge latches `a`, `b` and `c_in` into the shift registers and carry register, clears the counter, and moves to RUN.
  - `start`=0 stays in IDLE.
- State RUN, each edge:
  - the `full_adder` input is (shA[0], shB[0], carry);
  - its sum bit shifts into the MSB of the partial-sum register (right shift);
  - shA and shB shift right;
  - the carry register takes the adder's `c_out`;
  - the counter increments.
  - On the edge where counter = WIDTH-1, i.e. the last bit:
    - copy the completed partial sum to `sum`;
    - copy the final carry to `c_out`;
    - go to DONE.
- State DONE: `done`=1 for exactly one cycle, then unconditionally back to IDLE.
- `start` is ignored in RUN and DONE; holding it high does not queue a request. A new request is accepted in the first IDLE cycle, so back-to-back operations cost WIDTH+2 cycles each.
- Latency: the start edge is edge 0; `done` is high during the cycle after edge WIDTH+1.
- `busy` equals (state != IDLE) and is registered.
- `sum` and `c_out` hold the last completed result through subsequent RUN phases. They change only on entry to DONE or on reset.
- Arithmetic: unsigned modulo 2^WIDTH. `c_out` is the carry out of bit WIDTH-1.
- Counter width is $clog2(WIDTH) bits, minimum 1. WIDTH=1 completes in a single RUN cycle.
- Operand inputs may change freely after the start edge without affecting the result.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- When defined:
  - adds output port `ovf` (1 bit), a registered two's-complement overflow flag;
  - `ovf` = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), captured on entry to DONE alongside `sum`;
  - `ovf` resets to 0 and holds like `sum`.
- When undefined: no `ovf` port and no overflow logic; all other behaviour is identical.

Test Plan (WIDTH=8):
- Carry-out wrap: `rst_n` low 2 cycles, then a=8'hFF, b=8'h01, `c_in`=0, `start` pulsed. Required: `busy`=1 next cycle; `done` pulse after edge 9; `sum`=8'h00; `c_out`=1.
- Carry-in used: a=8'h5A, b=8'h3C, `c_in`=1. Required: `sum`=8'h97, `c_out`=0; `a` and `b` changed to 8'h00 one cycle after start do not alter the result.
- Start held high: `start` held high for 20 cycles with a=8'h10, b=8'h20. Required: two operations, each with exactly one `done` pulse and `sum`=8'h30; gap between `done` pulses = 10 cycles.
- Reset mid-operation: `rst_n`=0 on the 4th RUN cycle. Required: `busy`=0, `sum`=0, `c_out`=0, no `done` pulse. A following a=8'h01, b=8'h01 yields `sum`=8'h02.
- Outputs hold during RUN: after the FF+01 result, start 8'h7F+8'h01. Required: `sum` stays 8'h00 throughout RUN, then 8'h80 with `c_out`=0 at `done`.
- Overflow flag (SERIAL_ADD_OVF_EN defined): 8'h7F+8'h01 gives `ovf`=1; 8'hFF+8'h01 gives `ovf`=0; 8'h80+8'h80 gives `sum`=8'h00, `c_out`=1, `ovf`=1.
